serial_add_ctrl: RTL
====================

# serial_add_ctrl

Bit-serial addition controller. It sequences a single full-adder bit slice (the team's `fa` cell) over `WIDTH` clock cycles to add two `WIDTH`-bit operands plus carry-in, trading area for latency. It sits between a requester issuing a start/operand pulse and any consumer of the registered sum/carry result, and it owns the operand shifters, carry flop, bit counter and FSM around the shared adder slice.

## Interface
- `WIDTH`, default 8: operand/sum width in bits; legal range ≥ 1.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  request; sampled on `clk` rising edge; accepted only when the FSM is in IDLE.
- `a`  in  WIDTH  operand A, captured on an accepted start.
- `b`  in  WIDTH  operand B, captured on an accepted start.
- `cin`  in  1  carry-in, captured on an accepted start.
- `busy`  out  1  high while an addition is in progress (RUN).
- `done`  out  1  one-cycle pulse: `sum`/`cout` were just updated.
- `sum`  out  WIDTH  result register; holds its value between completions.
- `cout`  out  1  carry-out register; holds its value between completions.

## Operation
- Reset values: FSM = IDLE, `busy` = 0, `done` = 0, `sum` = 0, `cout` = 0.
- Reset also clears the operand shifters, the partial-sum shifter, the carry flop and the bit counter.
- FSM states: IDLE and RUN.
  - IDLE → RUN on `start`=1. On the same edge:
    - load the A shifter with `a` and the B shifter with `b`;
    - set the carry flop to `cin`;
    - set the counter to 0 and the partial-sum shifter to 0.
  - RUN, every edge:
    - feed the full-adder slice with A[0], B[0] and the carry flop;
    - shift A and B right by 1;
    - shift the slice sum into the partial-sum MSB (shift right);
    - load the slice carry into the carry flop;
    - increment the counter.
  - RUN → IDLE on the edge where the counter equals `WIDTH`-1 (the last bit). On that edge:
    - `sum` ← final partial sum (including this bit);
    - `cout` ← slice carry;
    - `done` ← 1.
- `done` is registered. It is 1 for exactly the one cycle following the last RUN edge and 0 otherwise.
- `busy` = (state == RUN), decoded combinationally from the state register.
- `start` while RUN is ignored: no queuing, and neither operands nor result are disturbed.
- `sum`/`cout` change only at completion. They are never visible partially, even while a new operation runs.
- Counter width is $clog2(WIDTH)+1 bits; it never wraps during a legal operation.
- Arithmetic: {`cout`,`sum`} = `a` + `b` + `cin`, modulo 2^(WIDTH+1), operands unsigned.
- `WIDTH`=1: RUN lasts exactly one edge.

## Timing
- Accepted start at edge k: `busy` is high from after edge k until after edge k+WIDTH.
- `done`=1 and the new `sum`/`cout` are valid in the cycle after edge k+WIDTH. Latency is WIDTH cycles from the accepting edge to the result.
- Back-to-back operation: `start` may be asserted in the cycle where `done`=1 (the FSM is already IDLE). It is accepted at that edge, giving one result every WIDTH+1 cycles at full throughput.
- If `start` stays high continuously, a new operation is accepted at every IDLE edge.
- Asynchronous `rst` in any state forces all reset values immediately. An in-flight operation is discarded and produces no `done`. After `rst` deasserts, the first `start` behaves normally.

## Test plan
- WIDTH=8, `a`=0x5A, `b`=0x3C, `cin`=0, start at edge k → `busy`=1 for 8 cycles; `done`=1 in the cycle after edge k+8; `sum`=0x96, `cout`=0.
- WIDTH=8, `a`=0xFF, `b`=0x01, `cin`=0 → `sum`=0x00, `cout`=1. Then `a`=0xFF, `b`=0x00, `cin`=1 → `sum`=0x00, `cout`=1. Then `a`=0x00, `b`=0x00, `cin`=0 → `sum`=0x00, `cout`=0.
- Start 0x10+0x20. Pulse `start` with `a`=0xAA, `b`=0x55 at RUN edge k+3 → the second request is ignored; the result is 0x30 with `cout`=0; exactly one `done` pulse; the FSM returns to IDLE.
- Start 0x12+0x34, then assert `rst` after 4 RUN edges → `busy`, `done`, `sum` and `cout` go to 0 asynchronously; no `done` follows. The next start with 0x01+0x02 yields `sum`=0x03.
- Hold `start`=1 with operands changing each accepted start: 0x01+0x01, then 0x80+0x80 → `done` pulses 9 cycles apart; results 0x02/`cout`=0 and 0x00/`cout`=1; `sum` stays 0x02 throughout the second operation until its `done`.
- WIDTH=1 build, `a`=1, `b`=1, `cin`=1 → `busy` for 1 cycle; `done` in the next cycle; `sum`=1, `cout`=1.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller.
// One full-adder slice is reused over WIDTH clock edges. Each edge adds one
// bit, LSB first. The sum/cout result registers update only when the
// operation completes.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] ps;
  logic [WIDTH-1:0] ps_next;
  logic             carry;
  logic             s_bit;
  logic             c_bit;
  logic [CW-1:0]    cnt;

  // Shared full-adder bit slice: returns {carry, sum}
  function automatic logic [1:0] fa_slice(input logic x, input logic y, input logic ci);
    return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

  // Slice evaluation and next partial sum (new bit enters at the MSB)
  always_comb begin
    {c_bit, s_bit}   = fa_slice(a_sh[0], b_sh[0], carry);
    ps_next          = ps >> 1;
    ps_next[WIDTH-1] = s_bit;
  end

  assign busy = (state == RUN);

  // FSM, datapath shifters and registered result; done is a one-cycle pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      ps    <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            ps    <= '0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          ps    <= ps_next;
          carry <= c_bit;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            sum   <= ps_next;
            cout  <= c_bit;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
